fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Schedules the shared sample RAM during FFT computation: between the bridge's
//  load phase (o_DATA_LOADED) and its write-out phase (i_CALC_END). Runs log2(N)
//  radix-2 DIT stages in place (input already bit-reversed). Per stage: issues N/2
//  butterfly operand-pair reads plus twiddle indices, then write-backs delayed to match the pipe.
// PARAMETERS
//  ADDR_WIDTH  12  sample RAM address width; also the width of i_SAMPLES_NUMBER
//  BF_LATENCY  4   butterfly unit latency, operands-valid to result-valid, cycles (>=1)
// PORTS
//  i_clk            in   1   clock
//  i_rstn           in   1   asynchronous reset, active-low
//  i_start          in   1   start pulse (driven from bridge o_DATA_LOADED)
//  i_SAMPLES_NUMBER in   12  N, sampled on accepted i_start
//  i_hold           in   1   1 = do not issue a new pair this cycle
//  o_rd_en          out  1   RAM dual read strobe
//  o_rd_addr_a/_b   out  AW  butterfly operand addresses
//  o_bf_valid       out  1   operands valid at butterfly input (o_rd_en delayed 1)
//  o_tw_index       out  AW  twiddle index, aligned with o_bf_valid
//  o_wr_en          out  1   RAM dual write strobe for butterfly results
//  o_wr_addr_a/_b   out  AW  write-back addresses
//  o_stage          out  4   current stage number
//  o_busy           out  1   high in ISSUE/DRAIN
//  o_CALC_END       out  1   level; N-point FFT complete
//  o_err            out  1   1-cycle pulse: i_start rejected, N invalid
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pipe delay lines cleared.
//  PIPE = 1 + BF_LATENCY (RAM read latency 1). Ops issued at cycle t write back at t+PIPE.
//  Valid N: power of two, 2..2048. L = log2(N), range 1..11.
//  States:
//   IDLE:  i_start with valid N -> latch N and L; stage=0; k=0; go to ISSUE.
//          i_start with invalid N -> o_err for 1 cycle; stay IDLE.
//   ISSUE: each cycle with i_hold=0, issue pair k (o_rd_en=1), then k++.
//          After k=N/2-1 is issued -> DRAIN. i_hold=1 stalls issue only.
//   DRAIN: wait until the last write-back of the stage has occurred (PIPE cycles
//          after last issue; i_hold ignored). Then:
//          stage<L-1 -> stage++, k=0, ISSUE; stage=L-1 -> DONE.
//   DONE:  o_CALC_END=1 (level). i_start with valid N clears it, same as IDLE start.
//  Start is ignored in ISSUE/DRAIN. No error is raised.
//  Address math at stage s, span=1<<s:
//   grp = k>>s; pos = k&(span-1);
//   a = (grp<<(s+1)) | pos; b = a + span;
//   tw = pos<<(L-1-s), always < N/2.
//  Write-back: a, b, valid shift registers of depth PIPE.
//   o_wr_* follow o_rd_* exactly PIPE cycles later, including hold gaps.
//  RAW safety: the next stage's first read is at least 1 cycle after the
//   previous stage's last write.
//  Cycle count: stall-free, ISSUE entered 1 cycle after start; total = L*(N/2+PIPE).
//   DONE is entered the cycle after the last write-back.
//  Reset mid-operation: abort immediately; no further o_wr_en; o_CALC_END=0.
// TESTING
//  N=8, BF_LATENCY=4, no hold, start at cycle 0:
//   s0 pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0;
//   s1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2;
//   s2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
//   Reads at cycles 1-4, 10-13, 19-22; writes at 6-9, 15-18, 24-27.
//   o_CALC_END rises at cycle 28.
//  N=2 -> single pair (0,1), tw 0. Read at cycle 1, write at 6, o_CALC_END at 7.
//  N=6, then N=0, then N=4096 (reads as 0) -> o_err pulse each time;
//   o_busy stays 0; no RAM strobes.
//  N=8 with i_hold high for cycles 2-3 -> reads at 1,4,5,6.
//   Writes at 6,9,10,11: gaps preserved.
//   Stage 1 first read at cycle 12. No read of an address precedes its pending write.
//  i_start pulsed during ISSUE -> ignored; sequence identical to the no-pulse run.
//  i_rstn low at cycle 12 of an N=8 run -> all outputs 0 next edge.
//   Fresh start gives the stall-free N=8 sequence.
//  N=2048 random i_hold -> 11 stages, 1024 reads and 1024 writes per stage.
//   Scoreboard matches the address model. o_stage reaches 10.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
// Sequencer <-> bridge/RAM/butterfly signal bundle.
// master = sequencer side (drives o_*), slave = surrounding datapath (drives i_*).
interface fft_stage_sequencer_if #(
    parameter int AW = 12
);
    logic          i_start;
    logic [AW-1:0] i_SAMPLES_NUMBER;
    logic          i_hold;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr_a;
    logic [AW-1:0] o_rd_addr_b;
    logic          o_bf_valid;
    logic [AW-1:0] o_tw_index;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr_a;
    logic [AW-1:0] o_wr_addr_b;
    logic [3:0]    o_stage;
    logic          o_busy;
    logic          o_CALC_END;
    logic          o_err;

    modport master (
        input  i_start, i_SAMPLES_NUMBER, i_hold,
        output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_bf_valid, o_tw_index,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage, o_busy, o_CALC_END, o_err
    );

    modport slave (
        output i_start, i_SAMPLES_NUMBER, i_hold,
        input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_bf_valid, o_tw_index,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage, o_busy, o_CALC_END, o_err
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT stage scheduler: reads pair k combinationally, writes it back 1+BF_LATENCY cycles later.
// i_hold stalls issue only; the write-back pipe keeps draining, preserving hold gaps.
module fft_stage_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int BF_LATENCY = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    fft_stage_sequencer_if.master bus
);
    localparam int AW   = ADDR_WIDTH;
    localparam int PIPE = 1 + BF_LATENCY;
    localparam int CW   = $clog2(PIPE + 1);
    localparam logic [AW-1:0] MAX_N = AW'(1) << (AW - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] half_n;
    logic [3:0]    l_reg;
    logic [3:0]    stage;
    logic [AW-1:0] k;
    logic [CW-1:0] drain_cnt;
    logic          err_q;

    logic [AW-1:0] n_in;
    logic          n_valid;
    logic [3:0]    l_in;
    logic          can_start;
    logic          issue;
    logic          last_pair;
    logic [AW-1:0] span, pos, grp, addr_a, addr_b, tw;

    logic [PIPE-1:0] v_sr;
    logic [AW-1:0]   a_sr [PIPE];
    logic [AW-1:0]   b_sr [PIPE];
    logic [AW-1:0]   tw_q;

    assign n_in      = bus.i_SAMPLES_NUMBER;
    assign n_valid   = (n_in >= AW'(2)) && (n_in <= MAX_N) && ((n_in & (n_in - AW'(1))) == '0);
    assign can_start = (state == ST_IDLE) || (state == ST_DONE);
    assign issue     = (state == ST_ISSUE) && !bus.i_hold;
    assign last_pair = (k == half_n - AW'(1));

    always_comb begin
        l_in = 4'd0;
        for (int i = 0; i < AW; i++) begin
            if (n_in[i]) l_in = 4'(i);
        end
    end

    // Butterfly pair k of stage s: insert a zero at bit s of k to get a, set it to get b.
    always_comb begin
        span   = AW'(1) << stage;
        pos    = k & (span - AW'(1));
        grp    = k >> stage;
        addr_a = (grp << (stage + 4'd1)) | pos;
        addr_b = addr_a | span;
        tw     = pos << (l_reg - 4'd1 - stage);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ST_IDLE;
            half_n    <= '0;
            l_reg     <= '0;
            stage     <= '0;
            k         <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= bus.i_start && can_start && !n_valid;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start && n_valid) begin
                        half_n <= n_in >> 1;
                        l_reg  <= l_in;
                        stage  <= '0;
                        k      <= '0;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        if (last_pair) begin
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end else begin
                            k <= k + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave only after the stage's final write-back cycle.
                    if (drain_cnt == CW'(PIPE - 1)) begin
                        if (stage == l_reg - 4'd1) begin
                            state <= ST_DONE;
                        end else begin
                            stage <= stage + 4'd1;
                            k     <= '0;
                            state <= ST_ISSUE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            v_sr <= '0;
            tw_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else begin
            v_sr    <= {v_sr[PIPE-2:0], issue};
            tw_q    <= issue ? tw : '0;
            a_sr[0] <= bus.o_rd_addr_a;
            b_sr[0] <= bus.o_rd_addr_b;
            for (int i = 1; i < PIPE; i++) begin
                a_sr[i] <= a_sr[i-1];
                b_sr[i] <= b_sr[i-1];
            end
        end
    end

    assign bus.o_rd_en     = issue;
    assign bus.o_rd_addr_a = issue ? addr_a : '0;
    assign bus.o_rd_addr_b = issue ? addr_b : '0;
    assign bus.o_bf_valid  = v_sr[0];
    assign bus.o_tw_index  = tw_q;
    assign bus.o_wr_en     = v_sr[PIPE-1];
    assign bus.o_wr_addr_a = a_sr[PIPE-1];
    assign bus.o_wr_addr_b = b_sr[PIPE-1];
    assign bus.o_stage     = stage;
    assign bus.o_busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign bus.o_CALC_END  = (state == ST_DONE);
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: N=8 tables, hold gaps, errors, reset abort, N=2048 scoreboard.
module tb_fft_stage_sequencer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.AW(12)) bus();
    fft_stage_sequencer #(.ADDR_WIDTH(12), .BF_LATENCY(4)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    int rd_c[$], rd_a[$], rd_b[$], rd_s[$], bv_c[$], tw_v[$], wr_c[$], wr_a[$], wr_b[$];
    int end_c, err_n, busy_n, stage_max;

    int a_t[12]     = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int b_t[12]     = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tw_t[12]    = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int rc_free[12] = '{1, 2, 3, 4, 10, 11, 12, 13, 19, 20, 21, 22};
    int rc_hold[12] = '{1, 4, 5, 6, 12, 13, 14, 15, 21, 22, 23, 24};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qg(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int any_out();
        return int'(|{bus.o_rd_en, bus.o_rd_addr_a, bus.o_rd_addr_b, bus.o_bf_valid, bus.o_tw_index,
                      bus.o_wr_en, bus.o_wr_addr_a, bus.o_wr_addr_b, bus.o_stage, bus.o_busy,
                      bus.o_CALC_END, bus.o_err});
    endfunction

    // Called just after a rising edge; cycle 0 is the cycle in which i_start is high.
    task automatic run(input int n, input int hold_lo, input int hold_hi, input bit rnd,
                       input int pulse_at, input int max_cyc);
        logic [31:0] nv;
        bit done;
        nv = n;
        rd_c.delete(); rd_a.delete(); rd_b.delete(); rd_s.delete();
        bv_c.delete(); tw_v.delete(); wr_c.delete(); wr_a.delete(); wr_b.delete();
        end_c = -1; err_n = 0; busy_n = 0; stage_max = 0;
        done = 1'b0;
        for (int rel = 0; rel <= max_cyc; rel++) begin
            bus.i_start          = (rel == 0) || (rel == pulse_at);
            bus.i_SAMPLES_NUMBER = nv[11:0];
            bus.i_hold           = rnd ? ($urandom_range(0, 3) == 0) : (rel >= hold_lo && rel <= hold_hi);
            @(negedge clk);
            if (bus.o_rd_en) begin
                rd_c.push_back(rel); rd_a.push_back(int'(bus.o_rd_addr_a));
                rd_b.push_back(int'(bus.o_rd_addr_b)); rd_s.push_back(int'(bus.o_stage));
            end
            if (bus.o_bf_valid) begin
                bv_c.push_back(rel); tw_v.push_back(int'(bus.o_tw_index));
            end
            if (bus.o_wr_en) begin
                wr_c.push_back(rel); wr_a.push_back(int'(bus.o_wr_addr_a));
                wr_b.push_back(int'(bus.o_wr_addr_b));
            end
            if (bus.o_err) err_n++;
            if (bus.o_busy) busy_n++;
            if (int'(bus.o_stage) > stage_max) stage_max = int'(bus.o_stage);
            if (rel > 0 && bus.o_CALC_END) begin
                end_c = rel;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        bus.i_start = 1'b0;
        bus.i_hold  = 1'b0;
    endtask

    task automatic check_n8(input string tag, input int rc[12], input int exp_end);
        check({tag, "_nrd"}, rd_c.size(), 12);
        check({tag, "_nwr"}, wr_c.size(), 12);
        check({tag, "_nbv"}, bv_c.size(), 12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_rdc%0d", tag, i), qg(rd_c, i), rc[i]);
            check($sformatf("%s_rda%0d", tag, i), qg(rd_a, i), a_t[i]);
            check($sformatf("%s_rdb%0d", tag, i), qg(rd_b, i), b_t[i]);
            check($sformatf("%s_bvc%0d", tag, i), qg(bv_c, i), rc[i] + 1);
            check($sformatf("%s_tw%0d", tag, i), qg(tw_v, i), tw_t[i]);
            check($sformatf("%s_wrc%0d", tag, i), qg(wr_c, i), rc[i] + 5);
            check($sformatf("%s_wra%0d", tag, i), qg(wr_a, i), a_t[i]);
            check($sformatf("%s_wrb%0d", tag, i), qg(wr_b, i), b_t[i]);
        end
        check({tag, "_end"}, end_c, exp_end);
        check({tag, "_err"}, err_n, 0);
    endtask

    initial begin
        int bad_n[3] = '{6, 0, 4096};
        int mism;
        int total;
        bus.i_start = 1'b0;
        bus.i_SAMPLES_NUMBER = '0;
        bus.i_hold = 1'b0;
        @(negedge clk);
        check("reset_outs", any_out(), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int j = 0; j < 3; j++) begin
            run(bad_n[j], -1, -1, 1'b0, -1, 4);
            check($sformatf("err_pulse_n%0d", bad_n[j]), err_n, 1);
            check($sformatf("err_busy_n%0d", bad_n[j]), busy_n, 0);
            check($sformatf("err_rd_n%0d", bad_n[j]), rd_c.size(), 0);
            check($sformatf("err_wr_n%0d", bad_n[j]), wr_c.size(), 0);
        end

        run(8, -1, -1, 1'b0, -1, 60);
        check_n8("n8", rc_free, 28);
        check("n8_stage_max", stage_max, 2);

        run(2, -1, -1, 1'b0, -1, 30);
        check("n2_nrd", rd_c.size(), 1);
        check("n2_rdc", qg(rd_c, 0), 1);
        check("n2_rda", qg(rd_a, 0), 0);
        check("n2_rdb", qg(rd_b, 0), 1);
        check("n2_tw", qg(tw_v, 0), 0);
        check("n2_wrc", qg(wr_c, 0), 6);
        check("n2_end", end_c, 7);

        run(8, 2, 3, 1'b0, -1, 60);
        check_n8("hold", rc_hold, 30);

        run(8, -1, -1, 1'b0, 3, 60);
        check_n8("pulse", rc_free, 28);

        run(8, -1, -1, 1'b0, -1, 11);
        check("abort_nrd", rd_c.size(), 6);
        check("abort_nwr", wr_c.size(), 4);
        rstn = 1'b0;
        #1;
        check("abort_outs", any_out(), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("abort_quiet%0d", c), int'(bus.o_wr_en | bus.o_CALC_END | bus.o_busy), 0);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run(8, -1, -1, 1'b0, -1, 60);
        check_n8("fresh", rc_free, 28);

        run(2048, -1, -1, 1'b1, -1, 40000);
        total = 11 * 1024;
        check("big_nrd", rd_c.size(), total);
        check("big_nwr", wr_c.size(), total);
        check("big_nbv", bv_c.size(), total);
        check("big_done", int'(end_c > 0), 1);
        check("big_stage_max", stage_max, 10);
        mism = 0;
        if (rd_c.size() == total && wr_c.size() == total && bv_c.size() == total) begin
            for (int i = 0; i < total; i++) begin
                int s, kk, span, pos, grp, ea, eb, etw;
                s    = i / 1024;
                kk   = i % 1024;
                span = 1 << s;
                pos  = kk & (span - 1);
                grp  = kk >> s;
                ea   = (grp << (s + 1)) | pos;
                eb   = ea + span;
                etw  = pos << (10 - s);
                if (rd_a[i] != ea || rd_b[i] != eb || rd_s[i] != s || tw_v[i] != etw) mism++;
                if (bv_c[i] != rd_c[i] + 1 || wr_c[i] != rd_c[i] + 5) mism++;
                if (wr_a[i] != ea || wr_b[i] != eb) mism++;
                if (kk == 0 && s > 0 && rd_c[i] <= wr_c[i-1]) mism++;
            end
        end
        check("big_model_mismatches", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
